// File: rtl/twiddle_gen.sv
// twiddle_gen: W_N^k (or its conjugate) from a quarter-wave cosine ROM by quadrant folding.
// Defining TWIDDLE_OUTREG_EN adds an output register stage, raising LATENCY from 2 to 3.
module twiddle_gen #(
    parameter int N  = 256,
    parameter int DW = 16,
    localparam int LOG2N = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [LOG2N-1:0]     k,
    input  logic                 inv,
    output logic                 out_valid,
    output logic signed [DW-1:0] wr,
    output logic signed [DW-1:0] wi,
    output logic [LOG2N-1:0]     out_k
);
`ifdef TWIDDLE_OUTREG_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif
    localparam int Q = N / 4;
    localparam logic [LOG2N-2:0] QI = (LOG2N-1)'(Q);

    function automatic logic signed [DW-1:0] cos_q(input int m);
        real x;
        x = $cos(2.0 * 3.14159265358979323846 * m / N) * ((2.0 ** (DW - 1)) - 1.0);
        return (DW)'(x < 0.0 ? -$rtoi(0.5 - x) : $rtoi(x + 0.5));
    endfunction

    logic signed [DW-1:0] rom [Q+1];
    for (genvar i = 0; i <= Q; i++) begin : g_rom
        assign rom[i] = cos_q(i);
    end

    logic [LOG2N-3:0] r_q;
    logic [LOG2N-2:0] qr_q;
    logic [1:0]       q_q;
    logic             inv_q, v1_q;
    logic [LOG2N-1:0] k1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            r_q   <= '0;
            qr_q  <= '0;
            q_q   <= '0;
            inv_q <= 1'b0;
            k1_q  <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                r_q   <= k[LOG2N-3:0];
                qr_q  <= QI - {1'b0, k[LOG2N-3:0]};
                q_q   <= k[LOG2N-1 -: 2];
                inv_q <= inv;
                k1_q  <= k;
            end
        end
    end

    // qr_q spans 0..Q, so r=0 reads the C[Q]=0 entry rather than wrapping
    logic signed [DW-1:0] a, b, wr_d, wf, wi_d;
    assign a    = rom[{1'b0, r_q}];
    assign b    = rom[qr_q];
    assign wr_d = q_q == 2'd0 ? a : q_q == 2'd1 ? -b : q_q == 2'd2 ? -a : b;
    assign wf   = q_q == 2'd0 ? -b : q_q == 2'd1 ? -a : q_q == 2'd2 ? b : a;
    assign wi_d = inv_q ? -wf : wf;

    logic                 v2_q;
    logic signed [DW-1:0] wr2_q, wi2_q;
    logic [LOG2N-1:0]     k2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            wr2_q <= '0;
            wi2_q <= '0;
            k2_q  <= '0;
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                wr2_q <= wr_d;
                wi2_q <= wi_d;
                k2_q  <= k1_q;
            end
        end
    end

    if (LATENCY == 3) begin : g_s3
        logic                 v3_q;
        logic signed [DW-1:0] wr3_q, wi3_q;
        logic [LOG2N-1:0]     k3_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v3_q  <= 1'b0;
                wr3_q <= '0;
                wi3_q <= '0;
                k3_q  <= '0;
            end else if (en) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    wr3_q <= wr2_q;
                    wi3_q <= wi2_q;
                    k3_q  <= k2_q;
                end
            end
        end
        assign out_valid = v3_q;
        assign wr        = wr3_q;
        assign wi        = wi3_q;
        assign out_k     = k3_q;
    end else begin : g_s2
        assign out_valid = v2_q;
        assign wr        = wr2_q;
        assign wi        = wi2_q;
        assign out_k     = k2_q;
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: scoreboard bench against a cos/sin reference model; main DUT N=256/DW=16
// plus exhaustive k x inv sweeps of N=64/DW=12 and N=8/DW=8 instances.
`timescale 1ns/1ps
module tb_twiddle_gen;
`ifdef TWIDDLE_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam real PI = 3.14159265358979323846;

    typedef struct { int k; bit iv; int due; } exp_t;
    typedef struct { int r; int i; int k; } out_t;

    logic clk = 1'b0, rst = 1'b1, rst_s = 1'b1, en = 1'b0, in_valid = 1'b0, inv = 1'b0;
    logic [7:0] k = '0;
    logic out_valid;
    logic signed [15:0] wr, wi;
    logic [7:0] out_k;
    int vectors = 0, miscompares = 0, adv_cnt = 0, cyc = 0;
    exp_t sb[$];
    out_t hist[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    twiddle_gen #(.N(256), .DW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .k(k), .inv(inv),
        .out_valid(out_valid), .wr(wr), .wi(wi), .out_k(out_k)
    );

    function automatic int rnd(real x);
        return x < 0.0 ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
    endfunction
    function automatic int exp_re(int kk, int n, int dw);
        return rnd($cos(2.0 * PI * kk / n) * (2.0 ** (dw - 1) - 1.0));
    endfunction
    function automatic int exp_im(int kk, int n, int dw, bit iv);
        real s = $sin(2.0 * PI * kk / n) * (2.0 ** (dw - 1) - 1.0);
        return rnd(iv ? s : -s);
    endfunction

    task automatic chk(string name, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive(bit e, bit v, int kk, bit iv);
        @(negedge clk);
        en = e; in_valid = v; k = 8'(kk); inv = iv;
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        out_t o;
        bit adv;
        adv = en && !rst;
        if (adv) begin
            adv_cnt++;
            if (in_valid) begin
                e.k = int'(k); e.iv = inv; e.due = adv_cnt + LAT - 1;
                sb.push_back(e);
            end
        end
        #1;
        if (adv) begin
            if (out_valid) begin
                o.r = int'(wr); o.i = int'(wi); o.k = int'(out_k);
                hist.push_back(o);
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL main unexpected output k=%0d wr=%0d wi=%0d", out_k, wr, wi);
                end else begin
                    e = sb.pop_front();
                    if (e.due != adv_cnt || int'(wr) != exp_re(e.k, 256, 16) ||
                        int'(wi) != exp_im(e.k, 256, 16, e.iv) || int'(out_k) != e.k) begin
                        miscompares++;
                        $display("FAIL main k=%0d inv=%0d: got (%0d,%0d) k=%0d adv=%0d, expected (%0d,%0d) k=%0d adv=%0d",
                                 e.k, e.iv, wr, wi, out_k, adv_cnt, exp_re(e.k, 256, 16),
                                 exp_im(e.k, 256, 16, e.iv), e.k, e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= adv_cnt) begin
                vectors++;
                miscompares++;
                e = sb.pop_front();
                $display("FAIL main missing output k=%0d due at advance %0d", e.k, e.due);
            end
        end
    end

    localparam int SN[2] = '{64, 8};
    localparam int SD[2] = '{12, 8};
    for (genvar g = 0; g < 2; g++) begin : g_ex
        localparam int NN = SN[g];
        localparam int DD = SD[g];
        localparam int LN = $clog2(NN);
        logic v = 1'b0, iv = 1'b0, ov;
        logic [LN-1:0] kk = '0, ok;
        logic signed [DD-1:0] r, i;
        bit done_x = 1'b0;
        int seen = 0;
        exp_t sbx[$];

        twiddle_gen #(.N(NN), .DW(DD)) dut (
            .clk(clk), .rst(rst_s), .en(1'b1), .in_valid(v), .k(kk), .inv(iv),
            .out_valid(ov), .wr(r), .wi(i), .out_k(ok)
        );

        initial begin : stim
            exp_t e;
            wait (!rst_s);
            for (int n = 0; n < 2 * NN; n++) begin
                @(negedge clk);
                v = 1'b1; kk = LN'(n % NN); iv = n >= NN;
                e.k = n % NN; e.iv = iv; e.due = cyc + LAT;
                sbx.push_back(e);
            end
            @(negedge clk);
            v = 1'b0;
        end

        always @(posedge clk) begin : chkx
            exp_t e;
            #1;
            if (ov) begin
                vectors++;
                if (sbx.size() == 0) begin
                    miscompares++;
                    $display("FAIL exh N=%0d unexpected output k=%0d", NN, ok);
                end else begin
                    e = sbx.pop_front();
                    seen++;
                    if (e.due != cyc || int'(r) != exp_re(e.k, NN, DD) ||
                        int'(i) != exp_im(e.k, NN, DD, e.iv) || int'(ok) != e.k) begin
                        miscompares++;
                        $display("FAIL exh N=%0d k=%0d inv=%0d: got (%0d,%0d) k=%0d cyc=%0d, expected (%0d,%0d) cyc=%0d",
                                 NN, e.k, e.iv, r, i, ok, cyc, exp_re(e.k, NN, DD),
                                 exp_im(e.k, NN, DD, e.iv), e.due);
                    end
                    if (seen == 2 * NN) done_x = 1'b1;
                end
            end else if (sbx.size() != 0 && sbx[0].due <= cyc) begin
                vectors++;
                miscompares++;
                e = sbx.pop_front();
                $display("FAIL exh N=%0d missing output k=%0d", NN, e.k);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int er[7] = '{32767, 23170, 0, -32767, 0, 0, 23170};
        int ei[7] = '{0, -23170, -32767, 0, 32767, 32767, -23170};
        int ek[7] = '{0, 32, 64, 128, 64, 192, 224};
        longint snap;
        repeat (3) @(negedge clk);
        chk("reset_state", {out_valid, wr, wi, out_k}, 0);
        rst = 1'b0; rst_s = 1'b0;

        hist.delete();
        drive(1, 1, 0, 0); drive(1, 1, 32, 0); drive(1, 1, 64, 0); drive(1, 1, 128, 0);
        drive(1, 1, 64, 1); drive(1, 1, 192, 0); drive(1, 1, 224, 1);
        repeat (5) drive(1, 0, 0, 0);
        chk("directed_count", hist.size(), 7);
        for (int n = 0; n < 7 && n < hist.size(); n++) begin
            chk($sformatf("directed%0d_wr", n), hist[n].r, er[n]);
            chk($sformatf("directed%0d_wi", n), hist[n].i, ei[n]);
            chk($sformatf("directed%0d_k", n), hist[n].k, ek[n]);
        end

        drive(1, 1, 32, 0); drive(1, 1, 64, 0);
        drive(0, 1, 99, 1);
        snap = {out_valid, wr, wi, out_k};
        repeat (3) begin
            @(negedge clk);
            chk("stall_freeze", {out_valid, wr, wi, out_k}, snap);
        end
        en = 1'b1; in_valid = 1'b0;
        repeat (4) drive(1, 0, 0, 0);

        drive(1, 1, 5, 0); drive(1, 0, 0, 0); drive(1, 1, 7, 1);
        repeat (4) drive(1, 0, 0, 0);

        drive(1, 1, 16, 0); drive(1, 1, 48, 1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; sb.delete();
        #1;
        chk("reset_async", {out_valid, wr, wi, out_k}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_held", {out_valid, wr, wi, out_k}, 0);
        rst = 1'b0;
        repeat (6) drive(1, 0, 0, 0);

        repeat (500)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        repeat (LAT + 4) drive(1, 0, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);

        for (int t = 0; t < 1000 && !(g_ex[0].done_x && g_ex[1].done_x); t++) @(negedge clk);
        chk("exhaustive_done", {g_ex[0].done_x, g_ex[1].done_x}, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
Parametrised twiddle-factor generator for the radix-2 FFT/IFFT datapath. It returns W_N^k = e^(-j*2*pi*k/N) for any k in 0..N-1, or its conjugate for the inverse transform. Only a quarter-wave cosine table is stored; the full circle is rebuilt by quadrant folding. A valid/enable pipeline lets the FFT controller stall it in lock-step with the butterfly.

Parameters:
N, 256, FFT size; power of two, 8..4096
DW, 16, output width, signed Q1.(DW-1); 8..18
LOG2N, $clog2(N), derived localparam; index width, not overridable

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
en  in  1  pipeline advance; 0 freezes every pipeline register
in_valid  in  1  k and inv are valid this cycle (sampled only when en=1)
k  in  LOG2N  twiddle exponent, 0..N-1
inv  in  1  1 = conjugate output (IFFT twiddle e^(+j*2*pi*k/N))
out_valid  out  1  wr/wi/out_k valid
wr  out  DW  real part, signed
wi  out  DW  imaginary part, signed
out_k  out  LOG2N  k echoed alongside its result (debug/alignment tag)

Behaviour:
- Table: C[m] = round(cos(2*pi*m/N) * (2^(DW-1)-1)), m = 0..Q, Q = N/4; Q+1 entries; round-half-away-from-zero, not truncation. Built at elaboration; synthesises to ROM/BRAM with two read ports.
- Folding: q = k[LOG2N-1:LOG2N-2], r = k[LOG2N-3:0]; A = C[r], B = C[Q-r].
  q=0: wr=+A, wi=-B; q=1: wr=-B, wi=-A; q=2: wr=-A, wi=+B; q=3: wr=+B, wi=+A.
  inv=1: wi negated after folding. |C| <= 2^(DW-1)-1, so negation never overflows; no saturation logic.
- r=0 reads C[Q] (= 0) on port B. Index Q-r is LOG2N-1 bits wide and must not be truncated.
- Pipeline, latency 2 en-qualified cycles:
  S1 registers r, Q-r, q, inv, k and valid.
  S2 registers the ROM reads with the sign/swap applied to wr, wi, out_k and out_valid.
- en=0: all stages hold, including out_valid and the data outputs; in_valid is ignored. en=1 with in_valid=0 inserts a bubble: out_valid=0 two advances later, and wr/wi keep their last values.
- Back-to-back: one new k accepted per en=1 cycle; throughput 1/cycle.
- Reset (async assert, held through a clock edge): out_valid=0, wr=0, wi=0, out_k=0, all internal valid bits 0. Reset mid-operation flushes in-flight samples, which are never emitted. First accepted sample after deassert appears 2 advances later.
- k beyond range cannot occur: k is exactly LOG2N bits and wraps naturally, so k=N-1 is legal.

Optional Feature:
TWIDDLE_OUTREG_EN: when defined, an extra output register stage S3 is added after S2, gated by the same en. Latency becomes 3, for timing closure at large N/DW.
Without the macro, latency is 2.
Reset values and stall rules are identical for both builds. The localparam LATENCY (2 or 3) reflects the build so the controller can align.

Test Plan:
- N=256, DW=16, en=1; k=0,32,64,128 back-to-back, inv=0 -> 2 cycles later, one per cycle: (32767,0), (23170,-23170), (0,-32767), (-32767,0); out_k matches.
- k=64 inv=1; k=192 inv=0; k=224 inv=1 -> (0,+32767), (0,+32767), (23170,-23170).
- Stall: issue k=32, drop en for 3 cycles, then raise -> out_valid rises only after 2 en=1 cycles with (23170,-23170); outputs are frozen during the stall.
- Bubble/reset: in_valid pattern 1,0,1 -> out_valid 1,0,1. Assert rst while 2 samples are in flight -> out_valid=0, wr=wi=0 immediately; no stale output after release.
- Exhaustive: N=64, DW=12, all k x inv (128 vectors) vs real model round(cos)/round(-sin) * 2047, exact match. Repeat for N=8, DW=8.
- Build with TWIDDLE_OUTREG_EN: repeat the first scenario -> identical values at latency 3.
